// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: one access at a time, LATENCY-cycle turnaround.
// Optional misalignment fault reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        byte_acc,
    input  logic        half_acc,
    input  logic        unsigned_ext,
    output logic        busy,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned AW       = ADDR_W + 2;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            fault_q, fault_d;
    logic            lat_we_q, lat_we_d;
    logic [AW-1:0]   lat_addr_q, lat_addr_d;
    logic [31:0]     lat_wdata_q, lat_wdata_d;
    logic            lat_byte_q, lat_byte_d;
    logic            lat_half_q, lat_half_d;
    logic            lat_uext_q, lat_uext_d;

    logic [31:0]     mem [DEPTH];

    logic            accept_c;
    logic            enter_resp_c;
    logic            op_we, op_byte, op_half, op_uext;
    logic [AW-1:0]   op_addr;
    logic [31:0]     op_wdata;
    logic [ADDR_W-1:0] op_idx;
    logic [31:0]     word_rd, byte_sh, half_sh, load_val;
    logic [3:0]      be_c;
    logic [31:0]     wdata_rep_c;
    logic            misal_c;
    logic            mem_we_c;
    logic            unused_c;

    assign unused_c = ^addr[31:AW];

    // With LATENCY=1 the accepting edge is also the RESP-entry edge, so the live inputs are the operation.
    always_comb begin
        op_we    = (LATENCY == 1) ? we           : lat_we_q;
        op_addr  = (LATENCY == 1) ? addr[AW-1:0] : lat_addr_q;
        op_wdata = (LATENCY == 1) ? wdata        : lat_wdata_q;
        op_byte  = (LATENCY == 1) ? byte_acc     : lat_byte_q;
        op_half  = (LATENCY == 1) ? half_acc     : lat_half_q;
        op_uext  = (LATENCY == 1) ? unsigned_ext : lat_uext_q;
        op_idx   = op_addr[AW-1:2];
    end

    // Lane selection, store replication and load extension
    always_comb begin
        word_rd = mem[op_idx];
        byte_sh = word_rd >> {op_addr[1:0], 3'b000};
        half_sh = word_rd >> {op_addr[1], 4'b0000};
        if (op_byte) begin
            be_c        = 4'b0001 << op_addr[1:0];
            wdata_rep_c = {4{op_wdata[7:0]}};
            load_val    = {{24{~op_uext & byte_sh[7]}}, byte_sh[7:0]};
        end else if (op_half) begin
            be_c        = op_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep_c = {2{op_wdata[15:0]}};
            load_val    = {{16{~op_uext & half_sh[15]}}, half_sh[15:0]};
        end else begin
            be_c        = 4'b1111;
            wdata_rep_c = op_wdata;
            load_val    = word_rd;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        misal_c = ~op_byte & (op_half ? op_addr[0] : (op_addr[1:0] != 2'b00));
`else
        misal_c = 1'b0;
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_byte_d  = lat_byte_q;
        lat_half_d  = lat_half_q;
        lat_uext_d  = lat_uext_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;

        accept_c = req & ~busy_q;
        if (accept_c) begin
            lat_we_d    = we;
            lat_addr_d  = addr[AW-1:0];
            lat_wdata_d = wdata;
            lat_byte_d  = byte_acc;
            lat_half_d  = half_acc;
            lat_uext_d  = unsigned_ext;
        end

        unique case (state_q)
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                if (accept_c) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        enter_resp_c = (state_d == RESP);
        mem_we_c     = enter_resp_c & op_we & ~misal_c;
        if (enter_resp_c) begin
            fault_d = misal_c;
            if (misal_c)     rdata_d = '0;
            else if (!op_we) rdata_d = load_val;
        end

        busy_d   = (state_d == WAIT);
        rvalid_d = enter_resp_c;
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_byte_q  <= 1'b0;
            lat_half_q  <= 1'b0;
            lat_uext_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_byte_q  <= lat_byte_d;
            lat_half_q  <= lat_half_d;
            lat_uext_q  <= lat_uext_d;
        end
    end

    // Storage survives CLR; only a committing store at RESP entry writes it
    always_ff @(posedge clk) begin
        if (!CLR && mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[op_idx][8*b +: 8] <= wdata_rep_c[8*b +: 8];
            end
        end
    end

    assign busy   = busy_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: LATENCY=2 and LATENCY=4 instances against a transaction-level memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        byte_acc = 1'b0, half_acc = 1'b0, unsigned_ext = 1'b0;
    logic [1:0]  busy_o, rvalid_o, fault_o;
    logic [31:0] rdata_o [2];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut_a (
        .clk(clk), .CLR(clr), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .byte_acc(byte_acc), .half_acc(half_acc), .unsigned_ext(unsigned_ext),
        .busy(busy_o[0]), .rvalid(rvalid_o[0]), .rdata(rdata_o[0]), .fault(fault_o[0]));

    dmem_responder #(.ADDR_W(10), .LATENCY(4)) u_dut_b (
        .clk(clk), .CLR(clr), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
        .byte_acc(byte_acc), .half_acc(half_acc), .unsigned_ext(unsigned_ext),
        .busy(busy_o[1]), .rvalid(rvalid_o[1]), .rdata(rdata_o[1]), .fault(fault_o[1]));

    typedef struct {
        int          inst;
        int          acc;
        int          due;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          b;
        bit          h;
        bit          u;
    } txn_t;

    txn_t        pend[$];
    logic [31:0] mmem [2][1024];
    logic [31:0] exp_rd [2];
    logic        seen_fault [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit is_free(input int i, input int e);
        foreach (pend[k]) if (pend[k].inst == i && e < pend[k].acc + lat_of(i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit has_pend(input int i);
        foreach (pend[k]) if (pend[k].inst == i) return 1'b1;
        return 1'b0;
    endfunction

    // Functional effect of one completed access on the model memory / expected rdata
    function automatic void resolve(input txn_t t, output bit f);
        int          idx, n, off;
        bit          mis;
        logic [31:0] w;
        logic [63:0] v, mask;
        idx = int'(t.a[11:2]);
        n   = t.b ? 1 : (t.h ? 2 : 4);
        off = t.b ? int'(t.a[1:0]) : (t.h ? (t.a[1] ? 2 : 0) : 0);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (!t.b && t.h && t.a[0]) || (!t.b && !t.h && t.a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        f = mis;
        if (mis) begin
            exp_rd[t.inst] = '0;
            return;
        end
        w = mmem[t.inst][idx];
        if (t.w) begin
            for (int k = 0; k < n; k++) w[8*(off+k) +: 8] = t.d[8*k +: 8];
            mmem[t.inst][idx] = w;
        end else begin
            mask = (64'd1 << (8*n)) - 64'd1;
            v = ({32'd0, w} >> (8*off)) & mask;
            if (!t.u && n < 4 && v[8*n-1]) v = v | ~mask;
            exp_rd[t.inst] = v[31:0];
        end
    endfunction

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit eb, ev, ef;
                eb = 1'b0; ev = 1'b0; ef = 1'b0;
                for (int k = 0; k < pend.size(); k++) begin
                    if (pend[k].inst == i) begin
                        if (cyc >= pend[k].acc && cyc < pend[k].due) eb = 1'b1;
                        if (pend[k].due == cyc) begin
                            ev = 1'b1;
                            resolve(pend[k], ef);
                        end
                    end
                end
                chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(eb));
                chk($sformatf("rvalid%0d", i), 32'(rvalid_o[i]), 32'(ev));
                chk($sformatf("rdata%0d", i), rdata_o[i], exp_rd[i]);
                if (ev) begin
                    chk($sformatf("fault%0d", i), 32'(fault_o[i]), 32'(ef));
                    seen_fault[i] = fault_o[i];
                end
            end
            for (int k = pend.size() - 1; k >= 0; k--) if (pend[k].due <= cyc) pend.delete(k);
        end
    end

    task automatic drive(input int i, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit b, input bit h, input bit u, input bit c);
        txn_t t;
        clr = c; req_a = r && (i == 0); req_b = r && (i == 1);
        we = w; addr = a; wdata = d; byte_acc = b; half_acc = h; unsigned_ext = u;
        if (r && !c && is_free(i, cyc + 1)) begin
            t = '{inst: i, acc: cyc + 1, due: cyc + lat_of(i), w: w, a: a, d: d, b: b, h: h, u: u};
            pend.push_back(t);
        end
        @(posedge clk); #1;
        if (c) begin
            pend.delete();
            exp_rd[0] = '0; exp_rd[1] = '0;
        end
    endtask

    task automatic idle1(input int i);
        drive(i, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic access(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit b, input bit h, input bit u);
        int n = 0;
        while (!is_free(i, cyc + 1) && n < 40) begin idle1(i); n++; end
        drive(i, 1'b1, w, a, d, b, h, u, 1'b0);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (has_pend(i) && n < 40) begin idle1(i); n++; end
        if (has_pend(i)) begin
            total++; bad++;
            $display("FAIL wait_idle%0d got=timeout want=complete", i);
        end
    endtask

    initial begin
        logic [31:0] rv;
        int          sz;
        exp_rd[0] = '0; exp_rd[1] = '0;
        seen_fault[0] = 1'b0; seen_fault[1] = 1'b0;

        // Reset then idle
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) idle1(0);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_rdata", rdata_o[1], 32'd0);

        // Known contents for the first 64 words of both instances
        for (int w = 0; w < 64; w++) begin
            access(0, 1'b1, 32'(w * 4), $urandom, 1'b0, 1'b0, 1'b0);
            access(1, 1'b1, 32'(w * 4), $urandom, 1'b0, 1'b0, 1'b0);
        end
        wait_idle(0); wait_idle(1);

        // Word store/load
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        access(0, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        chk("word_ld", rdata_o[0], 32'hDEADBEEF);

        // Byte/half extension
        access(0, 1'b1, 32'h20, 32'h80FF7F01, 1'b0, 1'b0, 1'b0);
        access(0, 1'b0, 32'h23, 32'd0, 1'b1, 1'b0, 1'b0); wait_idle(0);
        chk("sbyte_ld", rdata_o[0], 32'hFFFFFF80);
        access(0, 1'b0, 32'h23, 32'd0, 1'b1, 1'b0, 1'b1); wait_idle(0);
        chk("ubyte_ld", rdata_o[0], 32'h00000080);
        access(0, 1'b0, 32'h22, 32'd0, 1'b0, 1'b1, 1'b0); wait_idle(0);
        chk("shalf_ld", rdata_o[0], 32'hFFFF80FF);
        access(0, 1'b1, 32'h21, 32'h000000AA, 1'b1, 1'b0, 1'b0);
        access(0, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 1'b0); wait_idle(0);
        chk("byte_st", rdata_o[0], 32'h80FFAA01);

        // Back-to-back store->load and an ignored request during busy
        access(0, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, 1'b0);
        access(0, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b1, 32'h40, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        chk("b2b_ld", rdata_o[0], 32'h12345678);
        access(0, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0); wait_idle(0);
        chk("ignored_st", rdata_o[0], 32'h12345678);

        // Reset during the second WAIT cycle of a LATENCY=4 store
        access(1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0); wait_idle(1);
        access(1, 1'b1, 32'h80, 32'h00000055, 1'b0, 1'b0, 1'b0);
        idle1(1);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        access(1, 1'b0, 32'h80, 32'd0, 1'b0, 1'b0, 1'b0); wait_idle(1);
        chk("clr_drop", rdata_o[1], 32'hCAFEF00D);

        // Misaligned word store
        access(0, 1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0, 1'b0);
        access(0, 1'b1, 32'h42, 32'h77777777, 1'b0, 1'b0, 1'b0); wait_idle(0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("align_fault", 32'(seen_fault[0]), 32'd1);
`else
        chk("align_fault", 32'(seen_fault[0]), 32'd0);
`endif
        access(0, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0); wait_idle(0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("align_mem", rdata_o[0], 32'h11111111);
`else
        chk("align_mem", rdata_o[0], 32'h77777777);
`endif

        // Random traffic, including requests while busy and rare resets
        for (int n = 0; n < 2000; n++) begin
            rv = $urandom;
            sz = int'($urandom_range(0, 3));
            drive(int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom),
                  {rv[31:12], 4'b0000, rv[7:0]}, $urandom,
                  (sz == 0 || sz == 3), (sz == 1 || sz == 3), 1'($urandom),
                  ($urandom_range(0, 99) == 0));
        end
        wait_idle(0); wait_idle(1);
        idle1(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the MEM-stage load/store initiator of the five-stage pipeline.
- Accepts one request at a time over a req/busy handshake.
- Holds storage in an internal word array and inserts LATENCY cycles of wait.
- Returns a one-cycle rvalid pulse with the sign/zero-extended load result, or an acknowledge for stores.
- Drives busy back to the pipeline as a stall source.

Parameters:
- ADDR_W, 10: word-address width; array depth = 2**ADDR_W words of 32 bits.
- LATENCY, 2: cycles from the accepting edge to the rvalid cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- CLR  in  1  reset, synchronous, active-high
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1=store, 0=load
- addr  in  32  byte address; bits [ADDR_W+1:2] index the word, upper bits ignored
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- byte_acc  in  1  byte access
- half_acc  in  1  halfword access; byte_acc has priority if both set
- unsigned_ext  in  1  loads: 1=zero-extend, 0=sign-extend
- busy  out  1  access in wait; new req ignored
- rvalid  out  1  one-cycle completion pulse (loads and stores)
- rdata  out  32  load result, valid while rvalid=1
- fault  out  1  misalignment flag, qualified by rvalid (see Optional Feature)

Behaviour:
- FSM states IDLE, WAIT, RESP; wait counter is 4 bits.
- Reset (CLR=1 at an edge): state=IDLE, busy=0, rvalid=0, rdata=0, fault=0, counter=0. Memory array contents are not changed by CLR.
- Acceptance: at an edge with req=1 and busy=0 (state IDLE or RESP), the block latches we, addr, wdata, size and ext.
  - LATENCY=1: next state is RESP.
  - LATENCY>1: next state is WAIT with counter=LATENCY-2.
- WAIT: busy=1, rvalid=0. Counter decrements each edge; the edge at counter=0 moves to RESP.
- Edge entering RESP:
  - Store: write the selected lanes.
  - Load: register rdata from the array contents at that edge.
- RESP: busy=0, rvalid=1 for exactly one cycle.
  - A req in RESP is accepted, giving back-to-back throughput of one access per LATENCY cycles.
  - With no req, the next state is IDLE.
- Timing: request accepted at edge k gives rvalid high during the cycle after edge k+LATENCY-1. busy is high for LATENCY-1 cycles.
- Ignored requests: req while busy=1 is ignored entirely; there is no queue and no error.
- Lane selection (little-endian):
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Word: all four lanes.
  - Stores update only the addressed bytes.
- Load extension:
  - Byte: bit 7 of the lane, or zero, fills [31:8].
  - Half: bit 15, or zero, fills [31:16].
- rdata is held until the next RESP entry.
- Read-after-write: a load accepted in the RESP cycle of a store to the same word returns the new data.
- Reset mid-operation: the pending access is dropped; an uncommitted store never writes and no rvalid is produced.
- CLR has priority over req in the same cycle.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined:
  - A half with addr[0]=1, or a word with addr[1:0]!=0, is misaligned.
  - It completes with normal latency and sets fault=1 with rvalid.
  - No write occurs and rdata=0.
- Undefined:
  - fault is tied 0.
  - Misaligned half/word accesses force the ignored low bits to 0 (half uses addr[1], word uses the whole word) and proceed normally.

Test Plan:
- Reset then idle: CLR=1 for 2 cycles, req=0 -> busy=0, rvalid=0, rdata=0 every cycle.
- Word store/load, LATENCY=2: store 0xDEADBEEF to 0x10 at edge 0 -> busy=1 one cycle, rvalid at cycle after edge 1. Load 0x10 -> rdata=0xDEADBEEF.
- Byte/half extension: word 0x80FF7F01 at 0x20.
  - Signed byte load at 0x23 -> 0xFFFFFF80.
  - Unsigned byte load at 0x23 -> 0x00000080.
  - Signed half load at 0x22 -> 0xFFFF80FF.
  - Byte store 0xAA at 0x21 -> word 0x80FFAA01.
- Back-to-back and ignored req: store 0x12345678 to 0x40; load 0x40 issued in its RESP cycle -> 0x12345678. A req raised during busy=1 produces no extra rvalid.
- Reset mid-wait, LATENCY=4: store 0x55 to 0x80, assert CLR at the second WAIT cycle -> no rvalid, and a later load 0x80 returns the old value.
- Alignment check:
  - With DMEM_ALIGN_CHECK_EN: word store to 0x42 -> rvalid=1, fault=1, memory unchanged.
  - Without it: the same store writes word 0x40 and fault=0.
